// File: rtl/dds_core.sv
// Phase-accumulator DDS with double-buffered tuning word and quarter-wave sine ROM.
// Define DDS_SYNC_EN to pass en/set through 2-flop synchronizers from a foreign domain.
module dds_core #(
   parameter int unsigned ACC_W   = 32,
   parameter int unsigned PHASE_W = 10,
   parameter int unsigned OUT_W   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic [ACC_W-1:0] m,
   input  logic             set,
   output logic [OUT_W-1:0] sample,
   output logic             sample_valid,
   output logic             wrap
);

   localparam int IdxW     = PHASE_W - 2;
   localparam int LutDepth = 2 ** IdxW;
   localparam int MagW     = OUT_W - 1;
   localparam logic [OUT_W-1:0] Mid = {1'b1, {(OUT_W-1){1'b0}}};

   // Quarter-wave entry, sampled at bin centres; sine by Taylor series at elaboration.
   function automatic logic [MagW-1:0] lut_entry(input int i);
      real x;
      real term;
      real s;
      x    = 3.14159265358979 / 2.0 * (real'(i) + 0.5) / real'(LutDepth);
      term = x;
      s    = x;
      for (int k = 1; k < 12; k++) begin
         term = -term * x * x / real'((2 * k) * (2 * k + 1));
         s    = s + term;
      end
      return MagW'($rtoi(real'((2 ** MagW) - 1) * s + 0.5));
   endfunction

   logic [MagW-1:0] rom [LutDepth];
   for (genvar gi = 0; gi < LutDepth; gi++) begin : g_rom
      assign rom[gi] = lut_entry(gi);
   end

   logic en_q;
   logic set_rise;

`ifdef DDS_SYNC_EN
   logic [1:0] en_sync_q;
   logic [2:0] set_sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_sync_q  <= '0;
         set_sync_q <= '0;
      end else begin
         en_sync_q  <= {en_sync_q[0], en};
         set_sync_q <= {set_sync_q[1:0], set};
      end
   end

   assign en_q     = en_sync_q[1];
   assign set_rise = set_sync_q[1] & ~set_sync_q[2];
`else
   logic set_prev_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) set_prev_q <= 1'b0;
      else        set_prev_q <= set;
   end

   assign en_q     = en;
   assign set_rise = set & ~set_prev_q;
`endif

   logic [ACC_W-1:0] acc_q;
   logic [ACC_W-1:0] tuning_q;
   logic             wrap_q;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc_q} + {1'b0, tuning_q};

   // Accumulation reads the pre-load tuning word; a load never disturbs the phase.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_q    <= '0;
         tuning_q <= '0;
         wrap_q   <= 1'b0;
      end else begin
         if (set_rise) tuning_q <= m;
         if (en_q) begin
            acc_q  <= sum[ACC_W-1:0];
            wrap_q <= sum[ACC_W];
         end else begin
            wrap_q <= 1'b0;
         end
      end
   end

   logic [PHASE_W-1:0] ph_q;
   logic               v1_q;
   logic [1:0]         quad;
   logic [IdxW-1:0]    idx;
   logic [IdxW-1:0]    addr;
   logic [MagW-1:0]    mag_q;
   logic               neg_q;
   logic               v2_q;
   logic [OUT_W-1:0]   sample_q;
   logic               valid_q;

   assign quad = ph_q[PHASE_W-1 -: 2];
   assign idx  = ph_q[IdxW-1:0];
   assign addr = quad[0] ? ~idx : idx;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ph_q     <= '0;
         v1_q     <= 1'b0;
         mag_q    <= '0;
         neg_q    <= 1'b0;
         v2_q     <= 1'b0;
         sample_q <= Mid;
         valid_q  <= 1'b0;
      end else begin
         ph_q    <= acc_q[ACC_W-1 -: PHASE_W];
         v1_q    <= en_q;
         mag_q   <= rom[addr];
         neg_q   <= quad[1];
         v2_q    <= v1_q;
         valid_q <= v2_q;
         if (!v2_q)      sample_q <= Mid;
         else if (neg_q) sample_q <= Mid - OUT_W'(mag_q);
         else            sample_q <= Mid + OUT_W'(mag_q);
      end
   end

   assign sample       = sample_q;
   assign sample_valid = valid_q;
   assign wrap         = wrap_q;

endmodule
